// File: rtl/issue_ctrl.sv
// Consumer end of the dual-slot issue queue: in-order 0/1/2 issue decision,
// RAW countdown scoreboard and mul/div occupancy tracking.
module issue_ctrl #(
    parameter int NREG       = 32,
    parameter int LOAD_LAT   = 2,
    parameter int MULDIV_LAT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 stall_in,
    input  logic [1:0]           head_valid,
    input  logic [1:0][1:0]      head_type,
    input  logic [1:0]           head_wen,
    input  logic [1:0][4:0]      head_rd,
    input  logic [1:0][4:0]      head_rs1,
    input  logic [1:0][4:0]      head_rs2,
    input  logic [1:0]           head_load,
    output logic [1:0]           issued_cnt,
    output logic [1:0]           issue_valid,
    output logic                 md_busy
);

    localparam int MAXLAT = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
    localparam int SBW    = $clog2(MAXLAT) + 1;
    localparam int MCW    = $clog2(MULDIV_LAT);

    localparam logic [1:0] T_ALU = 2'b00;
    localparam logic [1:0] T_MEM = 2'b01;
    localparam logic [1:0] T_MD  = 2'b10;
    localparam logic [1:0] T_BR  = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } md_state_e;

    md_state_e        st_q;
    logic [MCW-1:0]   md_cnt_q;
    logic             md_busy_q;
    logic [1:0]       iv_q;
    logic [SBW-1:0]   sb_q [NREG];
    logic [SBW-1:0]   sb_d [NREG];

    logic [1:0]       src_ok;
    logic [1:0]       is_md;
    logic [1:0]       is_mem;
    logic [1:0]       md_ok;
    logic             iss0;
    logic             iss1;
    logic             raw01;
    logic             waw01;
    logic             md_iss;
    logic [1:0]       set_en;
    logic [1:0][SBW-1:0] set_val;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_ok[i] = (head_rs1[i] == 5'd0 || sb_q[head_rs1[i]] == '0) &&
                        (head_rs2[i] == 5'd0 || sb_q[head_rs2[i]] == '0);
            is_md[i]  = head_type[i] == T_MD;
            is_mem[i] = head_type[i] == T_MEM;
            md_ok[i]  = ~is_md[i] | (st_q == S_IDLE);
        end
    end

    // Same-cycle RAW/WAW between the pair; slot 1 must wait a cycle for these.
    assign raw01 = head_wen[0] && head_rd[0] != 5'd0 &&
                   (head_rs1[1] == head_rd[0] || head_rs2[1] == head_rd[0]);
    assign waw01 = head_wen[0] && head_wen[1] && head_rd[0] == head_rd[1];

    assign iss0 = resetn & head_valid[0] & ~stall_in & ~flush &
                  src_ok[0] & md_ok[0];

    assign iss1 = iss0 & head_valid[1] & src_ok[1] & md_ok[1] &
                  (head_type[1] != T_BR) & ~raw01 & ~waw01 &
                  ~(is_mem[0] & is_mem[1]) & ~(is_md[0] & is_md[1]);

    assign issued_cnt = iss1 ? 2'd2 : {1'b0, iss0};
    assign md_iss     = (iss0 & is_md[0]) | (iss1 & is_md[1]);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            set_en[i]  = 1'b0;
            set_val[i] = '0;
            if (head_wen[i] && head_rd[i] != 5'd0) begin
                if (is_md[i]) begin
                    set_en[i]  = 1'b1;
                    set_val[i] = SBW'(MULDIV_LAT);
                end else if (is_mem[i] && head_load[i]) begin
                    set_en[i]  = 1'b1;
                    set_val[i] = SBW'(LOAD_LAT);
                end
            end
        end
        set_en[0] = set_en[0] & iss0;
        set_en[1] = set_en[1] & iss1;
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sb_d[r] = sb_q[r];
            if (!stall_in && sb_q[r] != '0)
                sb_d[r] = sb_q[r] - SBW'(1);
        end
        // A fresh set overrides the decrement on the same register.
        for (int i = 0; i < 2; i++) begin
            if (set_en[i])
                sb_d[head_rd[i]] = set_val[i];
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++)
                sb_d[r] = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++)
                sb_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                sb_q[r] <= sb_d[r];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q      <= S_IDLE;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
            iv_q      <= 2'b00;
        end else if (flush) begin
            st_q      <= S_IDLE;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
            iv_q      <= 2'b00;
        end else begin
            iv_q <= {iss1, iss0};
            unique case (st_q)
                S_IDLE: begin
                    if (md_iss) begin
                        st_q      <= S_BUSY;
                        md_cnt_q  <= MCW'(MULDIV_LAT - 1);
                        md_busy_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (md_cnt_q == '0) begin
                        st_q      <= S_IDLE;
                        md_busy_q <= 1'b0;
                    end else begin
                        md_cnt_q <= md_cnt_q - MCW'(1);
                    end
                end
                default: begin
                    st_q      <= S_IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign issue_valid = iv_q;
    assign md_busy     = md_busy_q;

endmodule
